t_state_ring_counter: RTL and testbench
=======================================

Name: t_state_ring_counter

Overview:
- One-hot T-state generator (ring counter) for the MPU control sequencer.
- Sits directly upstream of the control-word decoder. It produces the timing states T1..TN that qualify every control signal.
- Advances on the falling clock edge, so control outputs are stable before the rising edge that registers and the bus use.
- Supports early instruction end (variable-length instructions), HLT freeze, and a manual single-step mode for the trainer panel.

Parameters:
- NUM_T, 6, number of T-states per instruction (range 3..18). SAP-2 build uses 18.
- IDX_W, 5, width of the binary T-index output; must satisfy 2^IDX_W > NUM_T.

Ports:
- iClk  input  1  system clock; all state changes on negedge.
- iReset  input  1  asynchronous, active-high reset.
- iRestart  input  1  end current instruction early; next state is T1.
- iHalt  input  1  HLT decoded; freeze the ring after the current edge.
- iManual  input  1  1 = single-step mode; 0 = free-run.
- iStep  input  1  panel step request (debounced externally, level, asynchronous to nothing faster than iClk).
- oT  output  NUM_T  one-hot T-state vector; bit 0 = T1.
- oTIndex  output  IDX_W  binary index of the active state (0 = T1).
- oFetch  output  1  high during T1..T3 (fetch cycle).
- oLastT  output  1  high when the current state is the final one of the instruction (T_NUM_T, or iRestart asserted).
- oHalted  output  1  sticky halt indicator.

Behaviour:
- Reset (async, iReset=1): oT=1 (T1), oTIndex=0, oHalted=0, step-edge register=0. Outputs take these values immediately, not at a clock edge.
- State register updates only on negedge iClk. oTIndex and oFetch are registered alongside oT. oLastT is combinational from oT[NUM_T-1] | iRestart.
- Advance enable (adv):
  - Free-run (iManual=0): adv=1 on every negedge.
  - Manual (iManual=1): adv=1 only on the negedge where iStep=1 and stepPrev=0. stepPrev is registered from iStep on each negedge. One step is one T-state, regardless of how long iStep is held.
- Next-state priority, evaluated at each negedge:
  1. oHalted=1: hold every output. Only iReset clears the halt.
  2. iHalt=1 and adv: go to T1, set oHalted=1.
  3. iRestart=1 and adv: go to T1.
  4. adv: rotate left one bit. T_NUM_T wraps to T1.
  5. Otherwise: hold.
- iHalt and iRestart asserted together: halt wins.
- iRestart while already in T1: stay in T1. This is legal, not an error.
- Illegal vector: if oT is not one-hot (zero, or more than one bit set), the next adv edge forces T1. oTIndex always matches oT after any edge.
- Switching iManual mid-instruction takes effect at the next negedge. The current T-state is preserved.
- Reset mid-instruction: abandon the instruction and return to T1 immediately.
- oFetch = oT[0] | oT[1] | oT[2], registered.

Decomposition:
- Shared package/include: the NUM_T default, fetch-state count (3), and T1 encoding constant, so the decoder can index oT symbolically.
- Natural sub-module: t_ring_stage. It is a single negedge, async-reset flip-flop cell with load-one/load-zero/hold/shift-in controls. It is instantiated NUM_T times, with stage 0 resetting to 1 and all others to 0.
- Index encoder and step-edge detector stay in the top module.

Test Plan (NUM_T=6):
- Free-run: release reset, apply 7 negedges. oT sequence 000001→000010→000100→001000→010000→100000→000001. oFetch high for the first 3 states. oLastT high only at 100000.
- Early end: in T4 (001000), assert iRestart for one negedge. oT=000001 and oTIndex=0. oLastT is high during the iRestart cycle.
- Halt: in T5, assert iHalt together with iRestart. The next negedge gives oT=000001 and oHalted=1. After 10 further edges oT is unchanged. Asserting iReset keeps T1 and sets oHalted=0.
- Manual: set iManual=1 and hold iStep=1 for 5 negedges. The ring advances exactly one state (T1→T2). Drop and reassert iStep; it advances to T3.
- Async reset mid-cycle: in T3, assert iReset between clock edges. oT=000001 with no clock edge.
- Illegal state: force oT=000000 (or 010100) in simulation. The next negedge gives 000001 and oTIndex=0.

Source files
------------

// File: rtl/t_state_ring_counter_pkg.sv
// t_state_ring_counter_pkg: shared T-state constants and ring stage control codes.
package t_state_ring_counter_pkg;
    localparam int NUM_T_DEF = 6;
    localparam int FETCH_T = 3;
    localparam int T1_IDX = 0;
    typedef enum logic [1:0] {
        STG_HOLD,
        STG_SHIFT,
        STG_LOAD1,
        STG_LOAD0
    } stageCtl_e;
endpackage

// File: rtl/t_state_ring_counter_if.sv
// t_state_ring_counter_if: sequencer controls and T-state outputs of the ring counter.
interface t_state_ring_counter_if #(
    parameter int NUM_T = t_state_ring_counter_pkg::NUM_T_DEF,
    parameter int IDX_W = 5
);
    logic iRestart;
    logic iHalt;
    logic iManual;
    logic iStep;
    logic [NUM_T-1:0] oT;
    logic [IDX_W-1:0] oTIndex;
    logic oFetch;
    logic oLastT;
    logic oHalted;
    modport master(
        output iRestart, iHalt, iManual, iStep,
        input oT, oTIndex, oFetch, oLastT, oHalted
    );
    modport slave(
        input iRestart, iHalt, iManual, iStep,
        output oT, oTIndex, oFetch, oLastT, oHalted
    );
endinterface

// File: rtl/t_state_ring_counter_stage.sv
// t_ring_stage: one negedge ring flop with async reset to RST_VAL and load/shift/hold control.
module t_ring_stage
    import t_state_ring_counter_pkg::*;
#(
    parameter logic RST_VAL = 1'b0
) (
    input  logic      iClk,
    input  logic      iReset,
    input  stageCtl_e ctl,
    input  logic      shiftIn,
    output logic      q
);
    always_ff @(negedge iClk or posedge iReset)
        if (iReset) q <= RST_VAL;
        else q <= ctl == STG_LOAD1 ? 1'b1 :
                  ctl == STG_LOAD0 ? 1'b0 :
                  ctl == STG_SHIFT ? shiftIn : q;
endmodule

// File: rtl/t_state_ring_counter.sv
// t_state_ring_counter: one-hot T-state ring for the control sequencer, stepping on the falling edge.
module t_state_ring_counter
    import t_state_ring_counter_pkg::*;
#(
    parameter int NUM_T = NUM_T_DEF,
    parameter int IDX_W = 5
) (
    input logic iClk,
    input logic iReset,
    t_state_ring_counter_if.slave bus
);
    localparam logic [NUM_T-1:0] T1 = NUM_T'(1) << T1_IDX;
    logic [NUM_T-1:0] tq, nextT;
    logic [IDX_W-1:0] nextIdx;
    logic stepPrev, adv, active, ldT1, oneHot;
    stageCtl_e ctl [NUM_T];
    assign oneHot = (tq != '0) && ((tq & (tq - NUM_T'(1))) == '0);
    assign adv = bus.iManual ? (bus.iStep & ~stepPrev) : 1'b1;
    assign active = ~bus.oHalted & adv;
    // A corrupted vector is recovered exactly like an early end: back to T1.
    assign ldT1 = ~oneHot | bus.iHalt | bus.iRestart;
    assign nextT = !active ? tq : ldT1 ? T1 : {tq[NUM_T-2:0], tq[NUM_T-1]};
    always_comb begin
        nextIdx = '0;
        for (int i = 0; i < NUM_T; i++) begin
            if (nextT[i]) nextIdx = nextIdx | IDX_W'(i);
            ctl[i] = !active ? STG_HOLD : ldT1 ? (i == T1_IDX ? STG_LOAD1 : STG_LOAD0) : STG_SHIFT;
        end
    end
    for (genvar i = 0; i < NUM_T; i++) begin : genStage
        t_ring_stage #(.RST_VAL(1'(i == T1_IDX))) uStage (
            .iClk(iClk),
            .iReset(iReset),
            .ctl(ctl[i]),
            .shiftIn(tq[(i + NUM_T - 1) % NUM_T]),
            .q(tq[i])
        );
    end
    assign bus.oT = tq;
    assign bus.oLastT = tq[NUM_T-1] | bus.iRestart;
    always_ff @(negedge iClk or posedge iReset)
        if (iReset) begin
            bus.oTIndex <= '0;
            bus.oFetch <= 1'b1;
            bus.oHalted <= 1'b0;
            stepPrev <= 1'b0;
        end else begin
            bus.oTIndex <= nextIdx;
            bus.oFetch <= |nextT[FETCH_T-1:0];
            bus.oHalted <= bus.oHalted | (active & bus.iHalt);
            stepPrev <= bus.iStep;
        end
endmodule

// File: tb/tb_t_state_ring_counter.sv
// tb_t_state_ring_counter: directed test-plan checks plus random stimulus against a T-index model.
module tb_t_state_ring_counter;
    localparam int N = 6;
    logic iClk = 1'b1;
    logic iReset = 1'b0;
    int checks = 0;
    int errors = 0;
    bit chk = 0;
    int badCnt = 0;
    int badSeen = 0;
    int mIdx = 0;
    bit mHalted = 0;
    bit mPrev = 0;

    t_state_ring_counter_if #(.NUM_T(N), .IDX_W(5)) bus();
    t_state_ring_counter #(.NUM_T(N), .IDX_W(5)) dut(.iClk(iClk), .iReset(iReset), .bus(bus));

    always #5 iClk = ~iClk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge iClk);
        #1;
    endtask

    // Model tracks only which T-state is active; the vector is 1 << mIdx.
    always @(negedge iClk or posedge iReset) begin
        if (iReset) begin
            mIdx = 0;
            mHalted = 0;
            mPrev = 0;
            badSeen = badCnt;
        end else begin
            bit adv;
            adv = !bus.iManual || (bus.iStep && !mPrev);
            mPrev = bus.iStep;
            if (!mHalted && adv) begin
                if (bus.iHalt) begin
                    mIdx = 0;
                    mHalted = 1;
                end else if (bus.iRestart || badCnt != badSeen) mIdx = 0;
                else mIdx = (mIdx + 1) % N;
                badSeen = badCnt;
            end
        end
    end

    always @(posedge iClk) begin
        if (chk && badCnt == badSeen) begin
            check("oT", int'(bus.oT), 1 << mIdx);
            check("oTIndex", int'(bus.oTIndex), mIdx);
            check("oFetch", int'(bus.oFetch), int'(mIdx < 3));
            check("oLastT", int'(bus.oLastT), int'(mIdx == N - 1 || bus.iRestart));
            check("oHalted", int'(bus.oHalted), int'(mHalted));
        end
    end

    initial begin
        int seqT [7] = '{2, 4, 8, 16, 32, 1, 2};
        int seqF [7] = '{1, 1, 0, 0, 0, 1, 1};
        int seqL [7] = '{0, 0, 0, 0, 1, 0, 0};
        bus.iRestart = 0;
        bus.iHalt = 0;
        bus.iManual = 0;
        bus.iStep = 0;
        #1 iReset = 1;
        #2;
        check("reset_oT", int'(bus.oT), 1);
        check("reset_idx", int'(bus.oTIndex), 0);
        check("reset_halted", int'(bus.oHalted), 0);
        tick();
        chk = 1;
        iReset = 0;
        for (int k = 0; k < 7; k++) begin
            tick();
            check("run_oT", int'(bus.oT), seqT[k]);
            check("run_fetch", int'(bus.oFetch), seqF[k]);
            check("run_last", int'(bus.oLastT), seqL[k]);
        end
        tick();
        tick();
        check("t4_oT", int'(bus.oT), 8);
        bus.iRestart = 1;
        #1 check("restart_last", int'(bus.oLastT), 1);
        tick();
        bus.iRestart = 0;
        check("restart_oT", int'(bus.oT), 1);
        check("restart_idx", int'(bus.oTIndex), 0);
        repeat (4) tick();
        check("t5_oT", int'(bus.oT), 16);
        bus.iHalt = 1;
        bus.iRestart = 1;
        tick();
        bus.iHalt = 0;
        bus.iRestart = 0;
        check("halt_oT", int'(bus.oT), 1);
        check("halt_flag", int'(bus.oHalted), 1);
        repeat (10) tick();
        check("halt_hold", int'(bus.oT), 1);
        iReset = 1;
        #2;
        check("unhalt_flag", int'(bus.oHalted), 0);
        check("unhalt_oT", int'(bus.oT), 1);
        tick();
        iReset = 0;
        bus.iManual = 1;
        bus.iStep = 1;
        repeat (5) tick();
        check("step_once", int'(bus.oT), 2);
        bus.iStep = 0;
        tick();
        bus.iStep = 1;
        tick();
        check("step_twice", int'(bus.oT), 4);
        #2 iReset = 1;
        #1 check("async_oT", int'(bus.oT), 1);
        check("async_idx", int'(bus.oTIndex), 0);
        tick();
        iReset = 0;
        bus.iStep = 0;
        bus.iManual = 0;
        tick();
        badCnt++;
        force dut.genStage[0].uStage.q = 1'b0;
        force dut.genStage[1].uStage.q = 1'b0;
        #1;
        release dut.genStage[0].uStage.q;
        release dut.genStage[1].uStage.q;
        tick();
        check("zero_fix_oT", int'(bus.oT), 1);
        check("zero_fix_idx", int'(bus.oTIndex), 0);
        badCnt++;
        force dut.genStage[0].uStage.q = 1'b0;
        force dut.genStage[2].uStage.q = 1'b1;
        force dut.genStage[4].uStage.q = 1'b1;
        #1;
        release dut.genStage[0].uStage.q;
        release dut.genStage[2].uStage.q;
        release dut.genStage[4].uStage.q;
        tick();
        check("multi_fix_oT", int'(bus.oT), 1);
        check("multi_fix_idx", int'(bus.oTIndex), 0);
        for (int c = 0; c < 3000; c++) begin
            tick();
            iReset = ($urandom_range(0, 99) == 0);
            bus.iRestart = ($urandom_range(0, 7) == 0);
            bus.iHalt = ($urandom_range(0, 59) == 0);
            if ($urandom_range(0, 49) == 0) bus.iManual = ~bus.iManual;
            bus.iStep = $urandom_range(0, 1) == 1;
        end
        tick();
        iReset = 0;
        tick();
        chk = 0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
